// File: rtl/exec_units.sv
// Execution units: NUM_ALU single-cycle ALU channels plus one blocking load
// channel, each ending in a single-entry completion register with valid/ready.
module exec_units #(
    parameter int XLEN    = 32,
    parameter int NUM_ALU = 2,
    parameter int ROB_W   = 6,
    parameter int PREG_W  = 6,
    parameter int FU_W    = $clog2(NUM_ALU + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic [NUM_ALU-1:0]          i_alu_valid,
    output logic [NUM_ALU-1:0]          o_alu_ready,
    input  logic [3*NUM_ALU-1:0]        i_alu_op,
    input  logic [XLEN*NUM_ALU-1:0]     i_alu_src0,
    input  logic [XLEN*NUM_ALU-1:0]     i_alu_src1,
    input  logic [XLEN*NUM_ALU-1:0]     i_alu_imm,
    input  logic [NUM_ALU-1:0]          i_alu_alusrc,
    input  logic [ROB_W*NUM_ALU-1:0]    i_alu_rob,
    input  logic [PREG_W*NUM_ALU-1:0]   i_alu_pdst,
    input  logic [NUM_ALU-1:0]          i_alu_regwrite,
    input  logic                        i_ld_valid,
    output logic                        o_ld_ready,
    input  logic [XLEN-1:0]             i_ld_src0,
    input  logic [XLEN-1:0]             i_ld_imm,
    input  logic [ROB_W-1:0]            i_ld_rob,
    input  logic [PREG_W-1:0]           i_ld_pdst,
    output logic                        o_mem_req,
    output logic [XLEN-1:0]             o_mem_addr,
    input  logic                        i_mem_gnt,
    input  logic                        i_mem_rvalid,
    input  logic [XLEN-1:0]             i_mem_rdata,
    output logic [NUM_ALU:0]            o_cmp_valid,
    input  logic [NUM_ALU:0]            i_cmp_ready,
    output logic [ROB_W*(NUM_ALU+1)-1:0]  o_cmp_rob,
    output logic [PREG_W*(NUM_ALU+1)-1:0] o_cmp_pdst,
    output logic [NUM_ALU:0]            o_cmp_regwrite,
    output logic [FU_W*(NUM_ALU+1)-1:0] o_cmp_fu,
    output logic [XLEN*(NUM_ALU+1)-1:0] o_cmp_data
);
    localparam int SHW = $clog2(XLEN);
    localparam int LD  = NUM_ALU;

    function automatic logic [XLEN-1:0] f_alu(
        input logic [2:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHW-1:0] sh;
        f_alu = a + b;
        sh    = b[SHW-1:0];
        unique case (op)
            3'b000: f_alu = a + b;
            3'b001: f_alu = a - b;
            3'b010: f_alu = a & b;
            3'b011: f_alu = a | b;
            3'b100: f_alu = a ^ b;
            3'b101: f_alu = a << sh;
            3'b110: f_alu = a >> sh;
            3'b111: f_alu = $signed(a) >>> sh;
        endcase
    endfunction

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu
        logic              r_vld;
        logic [XLEN-1:0]   r_data;
        logic [ROB_W-1:0]  r_rob;
        logic [PREG_W-1:0] r_pdst;
        logic              r_rw;
        logic [XLEN-1:0]   w_opb;
        logic              w_acc;

        assign w_opb = i_alu_alusrc[k] ? i_alu_imm[k*XLEN +: XLEN]
                                       : i_alu_src1[k*XLEN +: XLEN];
        assign o_alu_ready[k] = !i_flush && (!r_vld || i_cmp_ready[k]);
        assign w_acc = i_alu_valid[k] && o_alu_ready[k];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_rob  <= '0;
                r_pdst <= '0;
                r_rw   <= 1'b0;
            end else if (i_flush) begin
                r_vld <= 1'b0;
            end else if (w_acc) begin
                r_vld  <= 1'b1;
                r_data <= f_alu(i_alu_op[k*3 +: 3],
                                i_alu_src0[k*XLEN +: XLEN], w_opb);
                r_rob  <= i_alu_rob[k*ROB_W +: ROB_W];
                r_pdst <= i_alu_pdst[k*PREG_W +: PREG_W];
                r_rw   <= i_alu_regwrite[k];
            end else if (r_vld && i_cmp_ready[k]) begin
                r_vld <= 1'b0;
            end
        end

        assign o_cmp_valid[k]                = r_vld;
        assign o_cmp_data[k*XLEN +: XLEN]    = r_data;
        assign o_cmp_rob[k*ROB_W +: ROB_W]   = r_rob;
        assign o_cmp_pdst[k*PREG_W +: PREG_W] = r_pdst;
        assign o_cmp_regwrite[k]             = r_rw;
        assign o_cmp_fu[k*FU_W +: FU_W]      = FU_W'(k);
    end

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN
    } ld_state_t;

    ld_state_t         r_state, w_next;
    logic [XLEN-1:0]   r_ld_addr;
    logic [XLEN-1:0]   r_ld_data;
    logic [ROB_W-1:0]  r_ld_rob;
    logic [PREG_W-1:0] r_ld_pdst;
    logic              w_ld_acc;

    assign o_ld_ready = (r_state == S_IDLE) && !i_flush;
    assign w_ld_acc   = i_ld_valid && o_ld_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // A flushed load whose response is still outstanding must drain it.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_ld_acc) w_next = S_REQ;
            S_REQ: begin
                if (i_flush)        w_next = S_IDLE;
                else if (i_mem_gnt) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_flush)           w_next = i_mem_rvalid ? S_IDLE : S_DRAIN;
                else if (i_mem_rvalid) w_next = S_HOLD;
            end
            S_HOLD: if (i_flush || i_cmp_ready[LD]) w_next = S_IDLE;
            S_DRAIN: if (i_mem_rvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ld_addr <= '0;
            r_ld_data <= '0;
            r_ld_rob  <= '0;
            r_ld_pdst <= '0;
        end else begin
            if (w_ld_acc) begin
                r_ld_addr <= i_ld_src0 + i_ld_imm;
                r_ld_rob  <= i_ld_rob;
                r_ld_pdst <= i_ld_pdst;
            end
            if (r_state == S_WAIT && i_mem_rvalid && !i_flush)
                r_ld_data <= i_mem_rdata;
        end
    end

    assign o_mem_req  = (r_state == S_REQ);
    assign o_mem_addr = r_ld_addr;

    assign o_cmp_valid[LD]                  = (r_state == S_HOLD);
    assign o_cmp_data[LD*XLEN +: XLEN]      = r_ld_data;
    assign o_cmp_rob[LD*ROB_W +: ROB_W]     = r_ld_rob;
    assign o_cmp_pdst[LD*PREG_W +: PREG_W]  = r_ld_pdst;
    assign o_cmp_regwrite[LD]               = 1'b1;
    assign o_cmp_fu[LD*FU_W +: FU_W]        = FU_W'(LD);

endmodule

// File: doc/exec_units.md
EXEC_UNITS -- requirements
Module: exec_units

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter NUM_ALU, default 2: single-cycle ALU channels, indices 0..NUM_ALU-1; load channel index is NUM_ALU.
REQ-003 Parameter ROB_W, default 6: ROB number width.
REQ-004 Parameter PREG_W, default 6: physical register address width.
REQ-005 Parameter FU_W, default $clog2(NUM_ALU+1): channel index width.
REQ-006 i_clk  in  1  clock; all state on rising edge.
REQ-007 i_rst  in  1  synchronous, active-high reset.
REQ-008 i_flush  in  1  squash all in-flight work.
REQ-009 i_alu_valid / o_alu_ready  in/out  NUM_ALU  per-ALU issue handshake.
REQ-010 i_alu_op  in  3*NUM_ALU  op per ALU channel.
REQ-011 i_alu_src0, i_alu_src1, i_alu_imm  in  XLEN*NUM_ALU  operands; i_alu_alusrc  in  NUM_ALU  selects imm for operand1.
REQ-012 i_alu_rob, i_alu_pdst  in  ROB_W*NUM_ALU, PREG_W*NUM_ALU  tags; i_alu_regwrite  in  NUM_ALU.
REQ-013 i_ld_valid / o_ld_ready  in/out  1  load issue handshake; i_ld_src0, i_ld_imm  in  XLEN; i_ld_rob  in  ROB_W; i_ld_pdst  in  PREG_W.
REQ-014 o_mem_req  out 1, o_mem_addr  out XLEN, i_mem_gnt  in 1, i_mem_rvalid  in 1, i_mem_rdata  in XLEN: data-memory read port.
REQ-015 o_cmp_valid  out  NUM_ALU+1, i_cmp_ready  in  NUM_ALU+1: per-channel completion handshake.
REQ-016 o_cmp_rob  out ROB_W*(NUM_ALU+1), o_cmp_pdst  out PREG_W*(NUM_ALU+1), o_cmp_regwrite  out NUM_ALU+1, o_cmp_fu  out FU_W*(NUM_ALU+1), o_cmp_data  out XLEN*(NUM_ALU+1): completion payload.

Function
REQ-017 Each channel SHALL own one completion register; payload is valid only while o_cmp_valid bit is 1 and SHALL hold stable until i_cmp_ready fire.
REQ-018 ALU op decode SHALL be 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA; shifts use operand1[$clog2(XLEN)-1:0]; arithmetic wraps modulo 2^XLEN.
REQ-019 o_alu_ready[k] SHALL equal !o_cmp_valid[k] | i_cmp_ready[k], and be 0 while i_flush=1.
REQ-020 ALU accept (valid&ready) SHALL load the result into the completion register next edge: latency exactly 1 cycle, full throughput under continuous i_cmp_ready.
REQ-021 o_cmp_fu SHALL equal the channel index; load channel o_cmp_regwrite SHALL be 1.
REQ-022 Load FSM states IDLE, REQ, WAIT, HOLD, DRAIN; o_ld_ready SHALL be 1 only in IDLE with i_flush=0.
REQ-023 IDLE->REQ on load accept; latch rob, pdst, address = i_ld_src0+i_ld_imm.
REQ-024 REQ: o_mem_req=1, o_mem_addr stable; ->WAIT on i_mem_gnt.
REQ-025 WAIT: on i_mem_rvalid capture i_mem_rdata into load completion register, ->HOLD.
REQ-026 HOLD: o_cmp_valid[NUM_ALU]=1; ->IDLE on completion fire; one load in flight maximum.
REQ-027 i_flush SHALL clear every o_cmp_valid next edge; REQ->IDLE (o_mem_req drops next cycle); WAIT->DRAIN; HOLD->IDLE.
REQ-028 DRAIN: discard next i_mem_rvalid, ->IDLE; no completion produced.
REQ-029 Flush coincident with issue or completion fire: flush wins, no new result written; i_mem_rvalid in the flush cycle while in WAIT SHALL be discarded (->IDLE).
REQ-030 i_mem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-031 On i_rst: o_cmp_valid=0, load FSM=IDLE, o_mem_req=0, all payload and o_mem_addr registers=0; i_rst overrides i_flush and all handshakes.
REQ-032 Reset mid-load (any state) SHALL return to IDLE without DRAIN; subsequent stale i_mem_rvalid ignored per REQ-030.

Verification
REQ-033 ALU0 op=000 src0=5 imm=7 alusrc=1, cmp_ready=1 -> next cycle cmp_valid[0]=1, data=12, fu=0.
REQ-034 ALU1 op=111 src0=0x80000000 src1=4 -> data=0xF8000000; op=001 src0=0 src1=1 -> 0xFFFFFFFF.
REQ-035 ALU0 with cmp_ready[0]=0 two cycles -> payload held, o_alu_ready[0]=0; release -> fire, next issue accepted same cycle.
REQ-036 Load src0=0x100 imm=4, gnt after 2 cycles, rvalid 3 cycles later rdata=0xDEADBEEF -> mem_addr=0x104, cmp_valid[NUM_ALU]=1 with rdata, ld_ready=0 throughout.
REQ-037 Flush in WAIT, then rvalid -> no completion, ld_ready returns 1 the cycle after rvalid.
REQ-038 i_rst asserted in HOLD with cmp_ready=0 -> all outputs zero next cycle, FSM IDLE.
